// File: rtl/rt_gray2bin_arb.sv
// Round-robin arbiter sharing one Gray-to-binary converter among several requesters.
// States: IDLE | wait for a request, grant and capture; CONV | convert captured word; HOLD | present result until ready.
module rt_gray2bin_arb #(
  parameter int PARAM_BIT_NUM = 4,
  parameter int PARAM_REQ_NUM = 4,
  parameter int PARAM_ID_W    = $clog2(PARAM_REQ_NUM)
) (
  input  logic                                   rt_i_clk,
  input  logic                                   rt_i_rst_n,
  input  logic [PARAM_REQ_NUM-1:0]               rt_i_req,
  input  logic [PARAM_REQ_NUM*PARAM_BIT_NUM-1:0] rt_i_gray,
  output logic [PARAM_REQ_NUM-1:0]               rt_o_gnt,
  output logic                                   rt_o_valid,
  output logic [PARAM_BIT_NUM-1:0]               rt_o_bin,
  output logic [PARAM_ID_W-1:0]                  rt_o_id,
  input  logic                                   rt_i_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                   r_state;
  logic [PARAM_ID_W-1:0]    r_rr_ptr;
  logic [PARAM_BIT_NUM-1:0] r_gray;
  logic [PARAM_REQ_NUM-1:0] r_gnt;
  logic                     r_valid;
  logic [PARAM_BIT_NUM-1:0] r_bin;
  logic [PARAM_ID_W-1:0]    r_id;

  state_t                   w_state_nxt;
  logic [PARAM_ID_W-1:0]    w_ptr_nxt;
  logic [PARAM_BIT_NUM-1:0] w_gray_nxt;
  logic [PARAM_REQ_NUM-1:0] w_gnt_nxt;
  logic                     w_valid_nxt;
  logic [PARAM_BIT_NUM-1:0] w_bin_nxt;
  logic [PARAM_ID_W-1:0]    w_id_nxt;

  logic                     w_found;
  logic [PARAM_ID_W-1:0]    w_win;
  logic [PARAM_BIT_NUM-1:0] w_bin_conv;

  function automatic logic [PARAM_ID_W-1:0] f_wrap(input int a);
    f_wrap = PARAM_ID_W'((a >= PARAM_REQ_NUM) ? a - PARAM_REQ_NUM : a);
  endfunction

  // First requesting index at or after the pointer, wrapping past N-1.
  always_comb begin : p_arb
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < PARAM_REQ_NUM; i++) begin
      if (!w_found && rt_i_req[f_wrap(int'(r_rr_ptr) + i)]) begin
        w_found = 1'b1;
        w_win   = f_wrap(int'(r_rr_ptr) + i);
      end
    end
  end

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin : p_conv
    w_bin_conv = '0;
    for (int i = 0; i < PARAM_BIT_NUM; i++) begin
      w_bin_conv[i] = ^(r_gray >> i);
    end
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_ptr_nxt   = r_rr_ptr;
    w_gray_nxt  = r_gray;
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = r_valid;
    w_bin_nxt   = r_bin;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_gnt_nxt   = PARAM_REQ_NUM'(1) << w_win;
          w_gray_nxt  = rt_i_gray[int'(w_win)*PARAM_BIT_NUM +: PARAM_BIT_NUM];
          w_id_nxt    = w_win;
          w_ptr_nxt   = f_wrap(int'(w_win) + 1);
          w_state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        w_gnt_nxt   = '0;
        w_bin_nxt   = w_bin_conv;
        w_valid_nxt = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_valid && rt_i_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin : p_regs
    if (!rt_i_rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_gray   <= '0;
      r_gnt    <= '0;
      r_valid  <= 1'b0;
      r_bin    <= '0;
      r_id     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_gray   <= w_gray_nxt;
      r_gnt    <= w_gnt_nxt;
      r_valid  <= w_valid_nxt;
      r_bin    <= w_bin_nxt;
      r_id     <= w_id_nxt;
    end
  end

  assign rt_o_gnt   = r_gnt;
  assign rt_o_valid = r_valid;
  assign rt_o_bin   = r_bin;
  assign rt_o_id    = r_id;

endmodule

// File: doc/rt_gray2bin_arb.md
# rt_gray2bin_arb

Round-robin scheduler that shares one Gray-to-binary conversion datapath among `PARAM_REQ_NUM` requesters. Each requester presents a Gray-coded word, such as a synchronised FIFO pointer, and raises a request. The block grants one requester at a time, captures its word, converts it, and returns the binary result with the requester index on a valid/ready output port. It sits between clock-domain pointer synchronisers and the consumers that need binary pointer values, so a single converter serves all of them.

## Interface
- `PARAM_BIT_NUM`, 4: width of the Gray and binary words; legal range 2..32.
- `PARAM_REQ_NUM`, 4: number of requesters; legal range 2..8.
- `PARAM_ID_W`, `$clog2(PARAM_REQ_NUM)`: index width; derived, never overridden.
- `rt_i_clk`  in  1  single clock; all logic on its rising edge.
- `rt_i_rst_n`  in  1  asynchronous, active-low reset.
- `rt_i_req`  in  PARAM_REQ_NUM  per-requester request level.
- `rt_i_gray`  in  PARAM_REQ_NUM*PARAM_BIT_NUM  packed Gray words; requester k occupies bits [k*W +: W].
- `rt_o_gnt`  out  PARAM_REQ_NUM  one-hot grant pulse, one cycle.
- `rt_o_valid`  out  1  result valid.
- `rt_o_bin`  out  PARAM_BIT_NUM  converted binary word.
- `rt_o_id`  out  PARAM_ID_W  index of the requester that owns `rt_o_bin`.
- `rt_i_ready`  in  1  consumer accepts the result.

## Operation
- **FSM states:** IDLE, CONV, HOLD (binary state register).
- **IDLE:** if `rt_i_req` is nonzero, select the first set bit at or after the round-robin pointer `rr_ptr`, searching upward with wrap from N-1 to 0.
  - Register the one-hot `rt_o_gnt`.
  - Capture that requester's Gray word into an internal register.
  - Capture the index into `rt_o_id`.
  - Set `rr_ptr` to winner+1 mod N.
  - Go to CONV.
  - If `rt_i_req` is zero, stay in IDLE.
- **CONV:**
  - Clear `rt_o_gnt`.
  - Load `rt_o_bin` with the binary conversion of the captured word: bit i = XOR of Gray bits [W-1:i], computed combinationally from the captured register only.
  - Set `rt_o_valid`.
  - Go to HOLD.
- **HOLD:** when `rt_o_valid` and `rt_i_ready` are both high at an edge, clear `rt_o_valid` and go to IDLE. Otherwise hold all outputs.
- `rt_o_bin` and `rt_o_id` keep their last value after the handshake until the next CONV.
- **Requester contract:**
  - Hold `req` high and `gray` stable until `gnt` is seen.
  - After the grant, the requester may drop `req` or change `gray` freely.
  - A requester that still holds `req` after its grant is a new request and is served again in its round-robin turn.
- A request withdrawn before grant is ignored: no grant, no result.
- Requests arriving in CONV or HOLD wait. There is no queue beyond the request level.
- **Reset (any state):** asynchronous. State goes to IDLE, `rr_ptr`=0, `rt_o_gnt`=0, `rt_o_valid`=0, `rt_o_bin`=0, `rt_o_id`=0, captured word=0. An in-flight conversion is discarded and produces no result after release.

## Timing
- Request sampled at edge E0 (state IDLE): `rt_o_gnt` is high for the cycle E0..E1.
- At E1: `rt_o_valid` rises with `rt_o_bin`/`rt_o_id` valid. Latency from request sample to valid is 2 edges.
- Handshake completes at the first edge Eh ≥ E2 with `rt_i_ready`=1.
- The earliest next grant is at edge Eh+1.
- With `rt_i_ready` tied high, throughput is one result per 3 cycles.
- `rt_i_ready` is ignored when `rt_o_valid`=0.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- **Reset:** assert `rt_i_rst_n`=0 mid-simulation, off a clock edge → all outputs 0 immediately. After release with no request → outputs stay 0.
- **Single request:** requester 2, gray 4'b1101, `ready`=1 → `gnt`=4'b0100 for exactly one cycle, one edge after the request is sampled. `valid` rises the next edge with `bin`=4'b1001, `id`=2 and stays high one cycle.
- **Fairness:** all four `req` held high from reset, `ready`=1 → grants in order 0,1,2,3,0,1, spaced 3 cycles apart. Each `id` matches its grant.
- **Backpressure:** hold `ready`=0 for 5 cycles while `valid`=1 and other requests are pending → `valid`/`bin`/`id` stable and no `gnt`. Raise `ready` → handshake, then the next grant one edge later.
- **Exhaustive conversion:** requester 0 sweeps gray = i^(i>>1) for i=0..15 → `bin`=i each time. Repeat with `PARAM_BIT_NUM`=8 over 256 codes.
- **Reset mid-operation:** assert reset while in CONV for requester 1 → `valid` never rises for that transaction. After release, `rr_ptr`=0, so with `req`=4'b1010 the first grant goes to requester 1.
